cic_decimator: RTL and testbench

- Fixed-order CIC decimation filter:
  - 3 integrator stages, 3 comb stages, differential delay M=1.
  - Runtime-selectable decimation ratio R.
- Sits in the DFE filter array ahead of the compensation/FIR stages.
- The system clock is 3x the input sample rate, so an internal phase counter generates the input-sample enable.
- Output is gain-normalised by an arithmetic right shift and saturated back to DATA_WIDTH.

---
 rtl/cic_pkg.sv | 26 ++
 rtl/cic_integrator.sv | 29 ++
 rtl/cic_decimator.sv | 119 +++++++++++
 tb/tb_cic_decimator.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cic_pkg.sv
// Shared constants and the gain-normalisation shift table for the CIC decimator.
package cic_pkg;

   localparam int N_STAGES           = 3;
   localparam int R_W                = 5;
   localparam int CLK_PER_SAMPLE_DEF = 3;

   // Growth is N_STAGES*log2(Rmax), so R_W bits per stage covers R up to 31.
   function automatic int acc_w(input int data_width);
      return data_width + N_STAGES * R_W;
   endfunction

   function automatic logic [3:0] cic_shift(input logic [R_W-1:0] r);
      logic [3:0] sh;
      case (r) inside
         5'd0, 5'd1:    sh = 4'd0;
         5'd2:          sh = 4'd3;
         [5'd3:5'd4]:   sh = 4'd6;
         [5'd5:5'd8]:   sh = 4'd9;
         [5'd9:5'd16]:  sh = 4'd12;
         default:       sh = 4'd15;
      endcase
      return sh;
   endfunction

endpackage

// File: rtl/cic_integrator.sv
// One CIC integrator stage: a registered, wrapping accumulator advanced on en_i.
module cic_integrator
   import cic_pkg::*;
#(
   parameter int ACC_W = 31
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic [ACC_W-1:0] din_i,
   output logic [ACC_W-1:0] acc_o
);

   logic [ACC_W-1:0] acc_q;

   // Accumulate modulo 2^ACC_W; the combs undo any wrap-around.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= {ACC_W{1'b0}};
      end else if (en_i) begin
         acc_q <= acc_q + din_i;
      end else begin
         acc_q <= acc_q;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/cic_decimator.sv
// Third-order CIC decimator (M=1) with runtime ratio, shift normalisation and
// saturation; the input sample enable is derived from a clock phase counter.
module cic_decimator
   import cic_pkg::*;
#(
   parameter int DATA_WIDTH     = 16,
   parameter int CLK_PER_SAMPLE = CLK_PER_SAMPLE_DEF
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [R_W-1:0]        R,
   input  logic [DATA_WIDTH-1:0] x_in,
   output logic [DATA_WIDTH-1:0] x_out
);

   localparam int ACC_W = acc_w(DATA_WIDTH);
   localparam int PH_W  = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
   localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_PER_SAMPLE - 1);

   logic [PH_W-1:0]         phase_q, phase_d;
   logic [R_W-1:0]          dec_cnt_q, dec_cnt_d;
   logic [R_W-1:0]          r_lat_q, r_lat_d;
   logic                    smp_en_s, dec_en_s;
   logic [ACC_W-1:0]        x_ext_s;
   logic [ACC_W-1:0]        integ_s [N_STAGES];
   logic [ACC_W-1:0]        d1_q, d2_q, d3_q;
   logic signed [ACC_W-1:0] c1_s, c2_s, c3_s, scaled_s;
   logic [3:0]              shift_s;
   logic                    fits_s;
   logic [DATA_WIDTH-1:0]   sat_s;
   logic [DATA_WIDTH-1:0]   x_out_q;

   assign x_ext_s = {{(ACC_W-DATA_WIDTH){x_in[DATA_WIDTH-1]}}, x_in};

   for (genvar g = 0; g < N_STAGES; g++) begin : g_int
      logic [ACC_W-1:0] din_s;
      if (g == 0) begin : g_first
         assign din_s = x_ext_s;
      end else begin : g_rest
         assign din_s = integ_s[g-1];
      end
      cic_integrator #(.ACC_W(ACC_W)) u_int (
         .clk   (clk),
         .rst_n (rst_n),
         .en_i  (smp_en_s),
         .din_i (din_s),
         .acc_o (integ_s[g])
      );
   end

   // Phase and decimation counters; R is latched only at an output boundary.
   always_comb begin
      phase_d   = phase_q;
      dec_cnt_d = dec_cnt_q;
      r_lat_d   = r_lat_q;
      dec_en_s  = 1'b0;
      smp_en_s  = (phase_q == {PH_W{1'b0}});
      if (phase_q == PH_LAST) begin
         phase_d = {PH_W{1'b0}};
      end else begin
         phase_d = phase_q + PH_W'(1);
      end
      if (smp_en_s) begin
         if (dec_cnt_q == (r_lat_q - 5'd1)) begin
            dec_en_s  = 1'b1;
            dec_cnt_d = 5'd0;
            r_lat_d   = (R == 5'd0) ? 5'd1 : R;
         end else begin
            dec_cnt_d = dec_cnt_q + 5'd1;
         end
      end else begin
         dec_cnt_d = dec_cnt_q;
      end
   end

   // Comb chain, gain normalisation and saturation to the output width.
   always_comb begin
      c1_s     = $signed(integ_s[N_STAGES-1] - d1_q);
      c2_s     = c1_s - $signed(d2_q);
      c3_s     = c2_s - $signed(d3_q);
      shift_s  = cic_shift(r_lat_q);
      scaled_s = c3_s >>> shift_s;
      fits_s   = (&scaled_s[ACC_W-1:DATA_WIDTH-1]) | ~(|scaled_s[ACC_W-1:DATA_WIDTH-1]);
      if (fits_s) begin
         sat_s = scaled_s[DATA_WIDTH-1:0];
      end else if (scaled_s[ACC_W-1]) begin
         sat_s = {1'b1, {(DATA_WIDTH-1){1'b0}}};
      end else begin
         sat_s = {1'b0, {(DATA_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase_q   <= {PH_W{1'b0}};
         dec_cnt_q <= 5'd0;
         r_lat_q   <= 5'd1;
         d1_q      <= {ACC_W{1'b0}};
         d2_q      <= {ACC_W{1'b0}};
         d3_q      <= {ACC_W{1'b0}};
         x_out_q   <= {DATA_WIDTH{1'b0}};
      end else begin
         phase_q   <= phase_d;
         dec_cnt_q <= dec_cnt_d;
         r_lat_q   <= r_lat_d;
         if (dec_en_s) begin
            d1_q    <= integ_s[N_STAGES-1];
            d2_q    <= c1_s;
            d3_q    <= c2_s;
            x_out_q <= sat_s;
         end else begin
            x_out_q <= x_out_q;
         end
      end
   end

   assign x_out = x_out_q;

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: an arithmetic CIC model (closed-form
// integrator sums and comb differences) checked every cycle, plus literal values.
module tb_cic_decimator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [4:0]  R = 5'd1;
   logic [15:0] x_in = 16'd0;
   logic [15:0] x_out;

   cic_decimator dut (
      .clk   (clk),
      .rst_n (rst_n),
      .R     (R),
      .x_in  (x_in),
      .x_out (x_out)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   // Model state: input samples, third integrator value at each output point,
   // and the sample index of each output point.
   longint      xs[$];
   longint      ys[$];
   int          dn[$];
   int          t_m;
   int          next_dec;
   logic [15:0] exp_out;
   bit          spec_ok;
   bit          model_on = 1'b0;

   task automatic model_reset();
      xs.delete(); ys.delete(); dn.delete();
      t_m = 0; next_dec = 0; exp_out = 16'd0; spec_ok = 1'b1;
   endtask

   // Triple running sum of all samples before n (closed form binomial weights).
   function automatic longint y_at(int n);
      longint s = 0;
      for (int k = 0; k < n; k++) begin
         longint a = longint'(n - 1 - k);
         s += xs[k] * ((a * (a - 1)) / 2);
      end
      return s;
   endfunction

   task automatic model_edge();
      if (t_m % 3 == 0) begin
         int n;
         xs.push_back(longint'($signed(x_in)));
         n = xs.size() - 1;
         if (n == next_dec) begin
            int     sp, m, sh, s;
            longint yv[4];
            longint c3, sc;
            sp = (dn.size() == 0) ? 1 : n - dn[$];
            dn.push_back(n);
            ys.push_back(y_at(n));
            m = dn.size() - 1;
            spec_ok = 1'b1;
            for (int j = m - 2; j < m; j++)
               if (j >= 1 && (dn[j] - dn[j-1]) != sp) spec_ok = 1'b0;
            for (int i = 0; i < 4; i++) yv[i] = (m - i >= 0) ? ys[m-i] : 64'sd0;
            c3 = yv[0] - 3 * yv[1] + 3 * yv[2] - yv[3];
            c3 = (c3 <<< 33) >>> 33;
            s = 0;
            while ((1 << s) < sp) s++;
            sh = 3 * s;
            sc = c3 >>> sh;
            if (sc > 64'sd32767) sc = 64'sd32767;
            else if (sc < -64'sd32768) sc = -64'sd32768;
            exp_out = 16'(sc);
            next_dec = n + ((R == 5'd0) ? 1 : int'(R));
         end
      end
      t_m++;
   endtask

   // One clock: drive, advance model at the edge, compare on the falling edge.
   task automatic step(input int x);
      x_in = 16'(x);
      @(posedge clk);
      if (model_on) model_edge();
      @(negedge clk);
      if (model_on && spec_ok) begin
         vectors++;
         if (x_out !== exp_out) begin
            miscompares++;
            $display("FAIL cycle_cmp t=%0d: x_out=%0d required %0d",
                     t_m - 1, $signed(x_out), $signed(exp_out));
         end
      end
   endtask

   task automatic run_samples(input int cnt, input int x);
      repeat (3 * cnt) step(x);
   endtask

   task automatic check_lit(input string name, input int lit, input bit pin_model);
      vectors++;
      if ($signed(x_out) != lit) begin
         miscompares++;
         $display("FAIL %s: x_out=%0d required %0d", name, $signed(x_out), lit);
      end
      if (pin_model) begin
         vectors++;
         if ($signed(exp_out) != lit) begin
            miscompares++;
            $display("FAIL %s_model: model=%0d required %0d", name, $signed(exp_out), lit);
         end
      end
   endtask

   task automatic do_reset(input logic [4:0] r, input int x, input bit chk_async);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      model_on = 1'b0;
      R = r;
      x_in = 16'(x);
      if (chk_async) begin
         #1;
         check_lit("async_reset", 0, 1'b0);
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      model_on = 1'b1;
   endtask

   initial begin
      // R=8 DC 0.5: outputs 0, 1792, 12544, 16384 at samples 0, 8, 16, 24.
      do_reset(5'd8, 16384, 1'b0);
      run_samples(24, 16384);
      check_lit("r8_dc_out3", 12544, 1'b1);
      run_samples(1, 16384);
      check_lit("r8_dc_settle", 16384, 1'b1);
      run_samples(12, 16384);
      // Ratio change mid-cycle: boundary at 40 keeps R=8, then 44, 48, 52.
      R = 5'd4;
      run_samples(17, 16384);
      check_lit("rchg_settle", 16384, 1'b1);

      // Reset mid-operation with a non-zero input and output.
      do_reset(5'd8, -16384, 1'b1);
      run_samples(25, -16384);
      check_lit("r8_dc_neg", -16384, 1'b1);

      do_reset(5'd8, 32767, 1'b0);
      run_samples(25, 32767);
      check_lit("r8_fs_pos", 32767, 1'b1);

      do_reset(5'd8, -32768, 1'b0);
      run_samples(25, -32768);
      check_lit("r8_fs_neg", -32768, 1'b1);

      // R=5: SHIFT=9, 0.5*125/512 -> 4000; previous output 2880.
      do_reset(5'd5, 16384, 1'b0);
      run_samples(15, 16384);
      check_lit("r5_out2", 2880, 1'b1);
      run_samples(1, 16384);
      check_lit("r5_settle", 4000, 1'b1);

      // R=1 ramp: x_out after sample n equals x[n-3].
      do_reset(5'd1, 0, 1'b0);
      for (int n = 0; n < 12; n++) run_samples(1, n);
      check_lit("r1_ramp", 8, 1'b1);

      // R=0 behaves as R=1.
      do_reset(5'd0, 0, 1'b0);
      for (int n = 0; n < 6; n++) run_samples(1, 10 * n);
      check_lit("r0_ramp", 20, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
